// File: rtl/vit_pkg.sv
// Shared constants and types for the 64-state, rate-1/2 hard-decision Viterbi path-metric unit.
package vit_pkg;

   localparam int unsigned PM_W     = 8;
   localparam int unsigned BM_W     = 2;
   localparam int unsigned INIT_PM  = 64;
   localparam int unsigned N_STATES = 64;
   localparam int unsigned NORM_SUB = 2 ** (PM_W - 1);

   typedef logic [PM_W-1:0] pm_t;
   typedef logic [BM_W-1:0] bm_t;

endpackage

// File: rtl/acs_cell.sv
// Combinational add-compare-select for one successor state; ties resolve to predecessor a.
module acs_cell
   import vit_pkg::*;
#(
   parameter int unsigned PmW = PM_W,
   parameter int unsigned BmW = BM_W
) (
   input  logic [PmW-1:0] pm_a_i,
   input  logic [PmW-1:0] pm_b_i,
   input  logic [BmW-1:0] bm_a_i,
   input  logic [BmW-1:0] bm_b_i,
   output logic [PmW:0]   sel_o,
   output logic           dec_o
);

   logic [PmW:0] sum_a;
   logic [PmW:0] sum_b;

   // Sums carry one extra bit so the compare never sees a wrapped value.
   always_comb begin
      sum_a = {1'b0, pm_a_i} + {{(PmW + 1 - BmW){1'b0}}, bm_a_i};
      sum_b = {1'b0, pm_b_i} + {{(PmW + 1 - BmW){1'b0}}, bm_b_i};
      dec_o = (sum_b < sum_a);
      sel_o = dec_o ? sum_b : sum_a;
   end

endmodule

// File: rtl/acs_butterfly.sv
// Radix-2 ACS butterfly with registered path metrics and survivor decisions.
// Define ACS_SAT_EN to clamp overflowing metrics to all-ones instead of wrapping.
module acs_butterfly #(
   parameter int unsigned PM_W       = vit_pkg::PM_W,
   parameter int unsigned BM_W       = vit_pkg::BM_W,
   parameter bit          ZERO_STATE = 1'b0,
   parameter int unsigned INIT_PM    = vit_pkg::INIT_PM
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init,
   input  logic            in_valid,
   input  logic            norm,
   input  logic [PM_W-1:0] pm_in_a,
   input  logic [PM_W-1:0] pm_in_b,
   input  logic [BM_W-1:0] bm_a0,
   input  logic [BM_W-1:0] bm_a1,
   input  logic [BM_W-1:0] bm_b0,
   input  logic [BM_W-1:0] bm_b1,
   output logic [PM_W-1:0] pm_out_0,
   output logic [PM_W-1:0] pm_out_1,
   output logic            dec_0,
   output logic            dec_1,
   output logic            dec_valid,
   output logic            pm_msb
);

   localparam logic [PM_W-1:0] InitPm  = PM_W'(INIT_PM);
   localparam logic [PM_W-1:0] Pm0Init = ZERO_STATE ? '0 : InitPm;
   localparam logic [PM_W:0]   NormSub = (PM_W + 1)'(1) << (PM_W - 1);

   logic [PM_W-1:0] pm0_q, pm0_d, pm1_q, pm1_d;
   logic            dec0_q, dec0_d, dec1_q, dec1_d;
   logic            dv_q, dv_d;
   logic [PM_W:0]   sel0, sel1, nrm0, nrm1;
   logic            cdec0, cdec1;
   logic [PM_W-1:0] res0, res1;

   acs_cell #(
      .PmW (PM_W),
      .BmW (BM_W)
   ) u_acs0 (
      .pm_a_i (pm_in_a),
      .pm_b_i (pm_in_b),
      .bm_a_i (bm_a0),
      .bm_b_i (bm_b0),
      .sel_o  (sel0),
      .dec_o  (cdec0)
   );

   acs_cell #(
      .PmW (PM_W),
      .BmW (BM_W)
   ) u_acs1 (
      .pm_a_i (pm_in_a),
      .pm_b_i (pm_in_b),
      .bm_a_i (bm_a1),
      .bm_b_i (bm_b1),
      .sel_o  (sel1),
      .dec_o  (cdec1)
   );

   always_comb begin
      nrm0 = norm ? (sel0 - NormSub) : sel0;
      nrm1 = norm ? (sel1 - NormSub) : sel1;
   end

`ifdef ACS_SAT_EN
   logic sat_q, sat_d;

   always_comb begin
      res0  = nrm0[PM_W] ? '1 : nrm0[PM_W-1:0];
      res1  = nrm1[PM_W] ? '1 : nrm1[PM_W-1:0];
      sat_d = sat_q | (in_valid & (nrm0[PM_W] | nrm1[PM_W]));
   end

   // Debug-only sticky overflow flag; it has no output port.
   always_ff @(posedge clk) begin
      if (rst || init) sat_q <= 1'b0;
      else             sat_q <= sat_d;
   end
`else
   logic unused_ovf;

   always_comb begin
      res0       = nrm0[PM_W-1:0];
      res1       = nrm1[PM_W-1:0];
      unused_ovf = nrm0[PM_W] ^ nrm1[PM_W];
   end
`endif

   always_comb begin
      pm0_d  = pm0_q;
      pm1_d  = pm1_q;
      dec0_d = dec0_q;
      dec1_d = dec1_q;
      dv_d   = 1'b0;
      if (in_valid) begin
         pm0_d  = res0;
         pm1_d  = res1;
         dec0_d = cdec0;
         dec1_d = cdec1;
         dv_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || init) begin
         pm0_q  <= Pm0Init;
         pm1_q  <= InitPm;
         dec0_q <= 1'b0;
         dec1_q <= 1'b0;
         dv_q   <= 1'b0;
      end else begin
         pm0_q  <= pm0_d;
         pm1_q  <= pm1_d;
         dec0_q <= dec0_d;
         dec1_q <= dec1_d;
         dv_q   <= dv_d;
      end
   end

   assign pm_out_0  = pm0_q;
   assign pm_out_1  = pm1_q;
   assign dec_0     = dec0_q;
   assign dec_1     = dec1_q;
   assign dec_valid = dv_q;
   assign pm_msb    = pm0_q[PM_W-1] & pm1_q[PM_W-1];

endmodule

// File: tb/tb_acs_butterfly.sv
// Self-checking bench for acs_butterfly: directed literal cases plus randomized traffic
// checked every cycle against an integer reference model of the ACS rules.
module tb_acs_butterfly;

   localparam int PmMax  = 255;
   localparam int PmMod  = 256;
   localparam int Half   = 128;
   localparam int InitPm = 64;

   logic       clk = 1'b0;
   logic       rst, init, in_valid, norm;
   logic [7:0] pm_in_a, pm_in_b;
   logic [1:0] bm_a0, bm_a1, bm_b0, bm_b1;

   logic [7:0] pm0, pm1, zpm0, zpm1;
   logic       d0, d1, dv, msb, zd0, zd1, zdv, zmsb;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   int e0, e1, ez0;
   bit ed0, ed1, edv;

   always #5 clk = ~clk;

   acs_butterfly #(
      .PM_W       (8),
      .BM_W       (2),
      .ZERO_STATE (1'b1),
      .INIT_PM    (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init      (init),
      .in_valid  (in_valid),
      .norm      (norm),
      .pm_in_a   (pm_in_a),
      .pm_in_b   (pm_in_b),
      .bm_a0     (bm_a0),
      .bm_a1     (bm_a1),
      .bm_b0     (bm_b0),
      .bm_b1     (bm_b1),
      .pm_out_0  (pm0),
      .pm_out_1  (pm1),
      .dec_0     (d0),
      .dec_1     (d1),
      .dec_valid (dv),
      .pm_msb    (msb)
   );

   acs_butterfly #(
      .PM_W       (8),
      .BM_W       (2),
      .ZERO_STATE (1'b0),
      .INIT_PM    (64)
   ) dut_z (
      .clk       (clk),
      .rst       (rst),
      .init      (init),
      .in_valid  (in_valid),
      .norm      (norm),
      .pm_in_a   (pm_in_a),
      .pm_in_b   (pm_in_b),
      .bm_a0     (bm_a0),
      .bm_a1     (bm_a1),
      .bm_b0     (bm_b0),
      .bm_b1     (bm_b1),
      .pm_out_0  (zpm0),
      .pm_out_1  (zpm1),
      .dec_0     (zd0),
      .dec_1     (zd1),
      .dec_valid (zdv),
      .pm_msb    (zmsb)
   );

   function automatic int fold(input int v);
`ifdef ACS_SAT_EN
      return (v > PmMax) ? PmMax : v;
`else
      return v % PmMod;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the ACS rules, evaluated at each edge.
   always @(posedge clk) begin
      int sa0, sb0, sa1, sb1;
      if (rst || init) begin
         e0 = 0; ez0 = InitPm; e1 = InitPm;
         ed0 = 1'b0; ed1 = 1'b0; edv = 1'b0;
      end else if (in_valid) begin
         sa0 = pm_in_a + bm_a0;
         sb0 = pm_in_b + bm_b0;
         sa1 = pm_in_a + bm_a1;
         sb1 = pm_in_b + bm_b1;
         ed0 = (sb0 < sa0);
         ed1 = (sb1 < sa1);
         e0  = ed0 ? sb0 : sa0;
         e1  = ed1 ? sb1 : sa1;
         if (norm) begin
            e0 -= Half;
            e1 -= Half;
         end
         e0  = fold(e0);
         e1  = fold(e1);
         ez0 = e0;
         edv = 1'b1;
      end else begin
         edv = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pm_out_0", pm0, e0);
         chk("pm_out_1", pm1, e1);
         chk("dec_0", d0, ed0);
         chk("dec_1", d1, ed1);
         chk("dec_valid", dv, edv);
         chk("pm_msb", msb, (e0 >= Half && e1 >= Half));
         chk("z.pm_out_0", zpm0, ez0);
         chk("z.pm_out_1", zpm1, e1);
         chk("z.dec_valid", zdv, edv);
         chk("z.dec", {zd0, zd1}, {ed0, ed1});
         chk("z.pm_msb", zmsb, (ez0 >= Half && e1 >= Half));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int a, input int b, input int ba0, input int bb0, input int ba1,
                        input int bb1, input bit v, input bit n);
      pm_in_a  = 8'(a);
      pm_in_b  = 8'(b);
      bm_a0    = 2'(ba0);
      bm_b0    = 2'(bb0);
      bm_a1    = 2'(ba1);
      bm_b1    = 2'(bb1);
      in_valid = v;
      norm     = n;
   endtask

   initial begin
      rst = 1'b1;
      init = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      chk("rst pm0 zs1", pm0, 0);
      chk("rst pm1", pm1, 64);
      chk("rst dec_valid", dv, 0);
      chk("rst pm0 zs0", zpm0, 64);

      drive(10, 7, 0, 2, 2, 0, 1'b1, 1'b0);
      step();
      chk("acs pm0", pm0, 9);
      chk("acs dec0", d0, 1);
      chk("acs pm1", pm1, 7);
      chk("acs dec1", d1, 1);
      chk("acs dec_valid", dv, 1);

      drive(5, 4, 1, 2, 0, 0, 1'b1, 1'b0);
      step();
      chk("tie pm0", pm0, 6);
      chk("tie dec0", d0, 0);

      drive(200, 210, 1, 1, 1, 1, 1'b1, 1'b0);
      step();
      chk("pre-norm pm_msb", msb, 1);
      drive(200, 210, 1, 1, 1, 1, 1'b1, 1'b1);
      step();
      chk("norm pm0", pm0, 73);
      chk("norm pm1", pm1, 73);
      chk("norm dec", {d0, d1}, 0);
      chk("post-norm pm_msb", msb, 0);

      drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      step();
      chk("gap hold pm0", pm0, 73);
      chk("gap dec_valid", dv, 0);

      drive(9, 9, 1, 1, 1, 1, 1'b1, 1'b0);
      init = 1'b1;
      step();
      init = 1'b0;
      chk("init pm0", pm0, 0);
      chk("init pm1", pm1, 64);
      chk("init dec_valid", dv, 0);

      drive(254, 254, 2, 2, 2, 2, 1'b1, 1'b0);
      step();
`ifdef ACS_SAT_EN
      chk("ovf pm0", pm0, 255);
      chk("ovf pm1", pm1, 255);
`else
      chk("ovf pm0", pm0, 0);
      chk("ovf pm1", pm1, 0);
`endif
      chk("ovf dec0", d0, 0);

      for (int i = 0; i < 3000; i++) begin
         int a, b;
         bit v;
         a = $urandom_range(255);
         b = $urandom_range(255);
         v = ($urandom_range(3) != 0);
         // norm only when both metrics carry their MSB, matching the controller contract
         drive(a, b, $urandom_range(2), $urandom_range(2), $urandom_range(2),
               $urandom_range(2), v,
               v ? ((a >= Half) && (b >= Half) && ($urandom_range(1) == 1))
                 : ($urandom_range(1) == 1));
         rst  = ($urandom_range(63) == 0);
         init = ($urandom_range(31) == 0);
         step();
      end

      rst = 1'b0;
      init = 1'b0;
      in_valid = 1'b0;
      step();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
